dmac_engine: RTL and testbench
==============================

// Module: dmac_engine
// PURPOSE
//  DMA channel transfer engine; downstream consumer of the 32-bit resettable
//  descriptor registers (source, destination, size) in DMAC_Top. On start it
//  takes the bus via request/grant and copies SIZE words from src to dst,
//  one read then one write per word. It raises a sticky interrupt when done.
// PARAMETERS
//  DATA_W     32  bus data width
//  ADDR_W     32  byte-address width
//  CNT_W      16  word-count width
//  ADDR_STEP  4   byte increment per word
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       synchronous, active-high reset
//  start     in   1       1-cycle pulse; sampled only in IDLE
//  src_addr  in   ADDR_W  source base (from descriptor reg)
//  dst_addr  in   ADDR_W  destination base (from descriptor reg)
//  size      in   CNT_W   number of words to move
//  int_clr   in   1       clears interrupt
//  m_req     out  1       bus request
//  m_grant   in   1       bus grant from arbiter
//  m_addr    out  ADDR_W  bus address
//  m_wr      out  1       1=write cycle, 0=read cycle
//  m_dout    out  DATA_W  write data
//  m_din     in   DATA_W  read data, valid 1 cycle after read address
//  busy      out  1       high from start accept until DONE exit
//  interrupt out  1       sticky completion flag
// BEHAVIOUR
//  Reset: state=IDLE; m_req, m_wr, busy, interrupt = 0; m_addr, m_dout = 0.
//   Reset mid-transfer aborts at once; no further bus cycle is issued.
//  States:
//   IDLE  -- if start: latch src/dst/size into internal counters, busy=1.
//            If size==0, go to DONE; otherwise go to REQ.
//   REQ   -- m_req=1; go to RD_A when m_grant=1, else hold.
//   RD_A  -- m_addr=src_cnt, m_wr=0; go to RD_D.
//   RD_D  -- capture m_din into data_reg; go to WR.
//   WR    -- m_addr=dst_cnt, m_wr=1, m_dout=data_reg.
//            src_cnt+=ADDR_STEP, dst_cnt+=ADDR_STEP, cnt-=1.
//            If cnt==1, go to DONE; otherwise go to RD_A.
//   DONE  -- m_req=0, busy=0, set interrupt; go to IDLE next cycle.
//  m_req stays high from REQ through the last WR. Grant is sampled only in
//   REQ, and the arbiter must not revoke it while m_req=1.
//  Throughput: 3 cycles/word after grant. The first read address appears
//   1 cycle after grant is seen in REQ.
//  Address counters wrap modulo 2^ADDR_W silently. size is unsigned, so the
//   maximum transfer is 2^CNT_W-1 words.
//  start while busy is ignored. Input changes after acceptance have no
//   effect (values are latched).
//  interrupt: set in DONE, cleared by int_clr. When set and clear occur in the
//   same cycle, set wins.
//  m_wr=0 and m_addr holds its value in all states except RD_A and WR.
// STRUCTURE
//  Shared package dmac_pkg: state encodings (IDLE..DONE, 3-bit), ADDR_STEP,
//   and default widths.
//  One sub-module: dmac_addr_cnt (loadable, enable-increment ADDR_W
//   register). It is instantiated twice, for src and dst. The FSM, word
//   down-counter and data_reg are in dmac_engine.
// TESTING
//  1 Basic: src=0x100, dst=0x200, size=3, grant high -> reads 0x100/104/108
//    and writes 0x200/204/208 with matching data; interrupt rises 10 cycles
//    after start.
//  2 size=0 -> no m_req and no bus cycle; busy high 1 cycle; interrupt=1.
//  3 Grant delayed 5 cycles -> m_req held and m_addr idle; transfer then
//    proceeds as in 1.
//  4 Wrap: src=0xFFFF_FFFC, size=2 -> second read address is 0x0000_0000.
//  5 reset asserted during WR of word 2 of 4 -> next cycle IDLE with m_req=0,
//    busy=0, interrupt=0; no later writes.
//  6 start pulsed while busy is ignored. int_clr in the same cycle as DONE
//    leaves interrupt=1; a later int_clr drives it to 0.

Source files
------------

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared state encodings and default widths for the DMA channel engine
package dmac_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_ADDR_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/dmac_addr_cnt.sv
// rtl/dmac_addr_cnt.sv - loadable address register with fixed-step increment, wraps silently
module dmac_addr_cnt
  import dmac_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int STEP   = DEF_ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc) begin
      q <= q + ADDR_W'(STEP);
    end
  end

endmodule

// File: rtl/dmac_engine.sv
// rtl/dmac_engine.sv - single-channel DMA copy engine: bus request/grant, read-then-write per word,
// sticky completion interrupt
module dmac_engine
  import dmac_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  size,
  input  logic              int_clr,
  output logic              m_req,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              busy,
  output logic              interrupt
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic              accept;
  logic              enter_done;

  assign accept     = (state == ST_IDLE) && start;
  assign enter_done = (accept && (size == '0)) || ((state == ST_WR) && (cnt == CNT_W'(1)));
  assign m_dout     = data_reg;

  // Source advances as its read address leaves the bus, destination as its write does,
  // so each counter already holds the next word's address when it is presented.
  dmac_addr_cnt #(.ADDR_W(ADDR_W), .STEP(ADDR_STEP)) u_src_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .inc   (state == ST_RD_A),
    .din   (src_addr),
    .q     (src_q)
  );

  dmac_addr_cnt #(.ADDR_W(ADDR_W), .STEP(ADDR_STEP)) u_dst_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .inc   (state == ST_WR),
    .din   (dst_addr),
    .q     (dst_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      busy      <= 1'b0;
      interrupt <= 1'b0;
      cnt       <= '0;
      data_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt  <= size;
            busy <= 1'b1;
            if (size == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_REQ;
              m_req <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (m_grant) begin
            state  <= ST_RD_A;
            m_addr <= src_q;
            m_wr   <= 1'b0;
          end
        end
        ST_RD_A: begin
          state <= ST_RD_D;
        end
        ST_RD_D: begin
          data_reg <= m_din;
          m_addr   <= dst_q;
          m_wr     <= 1'b1;
          state    <= ST_WR;
        end
        ST_WR: begin
          m_wr <= 1'b0;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            m_req <= 1'b0;
          end else begin
            state  <= ST_RD_A;
            m_addr <= src_q;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Setting outranks a coincident clear, both on entry to and during DONE.
      interrupt <= enter_done || (state == ST_DONE) || (interrupt && !int_clr);
    end
  end

endmodule

// File: tb/tb_dmac_engine.sv
// tb/tb_dmac_engine.sv - scoreboard bench for dmac_engine: directed transfers, expected writes
// queued at issue and checked by an independent write monitor
module tb_dmac_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] size;
  logic        int_clr;
  logic        m_req;
  logic        m_grant;
  logic [31:0] m_addr;
  logic        m_wr;
  logic [31:0] m_dout;
  logic [31:0] m_din = 32'h0;
  logic        busy;
  logic        interrupt;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  writes_seen = 0;

  dmac_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .size      (size),
    .int_clr   (int_clr),
    .m_req     (m_req),
    .m_grant   (m_grant),
    .m_addr    (m_addr),
    .m_wr      (m_wr),
    .m_dout    (m_dout),
    .m_din     (m_din),
    .busy      (busy),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory model: read data for the address on the bus appears one cycle later.
  always @(posedge clk) m_din <= pat(m_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_wr === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", m_addr, m_dout);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", m_addr, e.addr);
        check("wr_data", m_dout, e.data);
      end
    end
  end

  task automatic push(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = d + 32'(4 * i);
      e.data = pat(s + 32'(4 * i));
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_int(input string tag);
    @(negedge clk);
    int_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    int_clr = 1'b0;
    check({tag, "_int_clr"}, {31'b0, interrupt}, 32'd0);
  endtask

  // Returns at the negedge of the first cycle with interrupt high (the DONE cycle).
  task automatic xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] n, input int gdelay, input bit glitch,
                      output int int_cyc, output int busy_cyc, output bit saw_req);
    logic [31:0] addr0;
    clear_int(tag);
    push(s, d, int'(n));
    addr0    = m_addr;
    m_grant  = (gdelay == 0);
    src_addr = s;
    dst_addr = d;
    size     = n;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    int_cyc  = -1;
    busy_cyc = 0;
    saw_req  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (busy) busy_cyc++;
      if (m_req) saw_req = 1'b1;
      if (gdelay > 0 && c <= gdelay) begin
        check({tag, "_req_held"}, {31'b0, m_req}, 32'd1);
        check({tag, "_addr_idle"}, m_addr, addr0);
      end
      if (c == gdelay) m_grant = 1'b1;
      if (glitch && c == 3) begin
        start    = 1'b1;
        src_addr = 32'hDEAD_0000;
        dst_addr = 32'hBEEF_0000;
        size     = 16'd9;
      end
      if (glitch && c == 4) start = 1'b0;
      if (interrupt) begin
        int_cyc = c;
        break;
      end
    end
  endtask

  int ic, bc, w0, wr_n;
  bit sr;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    int_clr  = 1'b0;
    m_grant  = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    size     = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_m_wr", {31'b0, m_wr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_int", {31'b0, interrupt}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_dout", m_dout, 32'd0);
    reset = 1'b0;

    // Basic copy with a start glitch while busy, then set-wins and later clear
    xfer("t1", 32'h100, 32'h200, 16'd3, 0, 1'b1, ic, bc, sr);
    check("t1_int_cycle", ic, 32'd10);
    check("t1_busy_cycles", bc, 32'd11);
    int_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    int_clr = 1'b0;
    check("t6_set_wins", {31'b0, interrupt}, 32'd1);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_req_after", {31'b0, m_req}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    clear_int("t6_later");

    // Zero-length transfer
    w0 = writes_seen;
    xfer("t2", 32'h500, 32'h600, 16'd0, 0, 1'b0, ic, bc, sr);
    check("t2_int_cycle", ic, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t2_busy_cycles", bc, 32'd1);
    check("t2_busy_after", {31'b0, busy}, 32'd0);
    check("t2_no_req", {31'b0, sr}, 32'd0);
    check("t2_no_writes", writes_seen - w0, 32'd0);

    // Grant delayed by five cycles
    xfer("t3", 32'h1000, 32'h2000, 16'd3, 5, 1'b0, ic, bc, sr);
    check("t3_int_cycle", ic, 32'd15);
    check("t3_busy_cycles", bc, 32'd16);
    check("t3_queue_empty", exp_q.size(), 32'd0);

    // Source address wraps through zero
    xfer("t4", 32'hFFFF_FFFC, 32'h300, 16'd2, 0, 1'b0, ic, bc, sr);
    check("t4_int_cycle", ic, 32'd7);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // Reset during the write of word 2 of 4
    clear_int("t5");
    push(32'h400, 32'h800, 2);
    w0       = writes_seen;
    wr_n     = 0;
    m_grant  = 1'b1;
    src_addr = 32'h400;
    dst_addr = 32'h800;
    size     = 16'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_wr) wr_n++;
      if (wr_n == 2) break;
      @(posedge clk);
      @(negedge clk);
    end
    check("t5_reached_wr2", wr_n, 32'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("t5_req", {31'b0, m_req}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_int", {31'b0, interrupt}, 32'd0);
    check("t5_wr", {31'b0, m_wr}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t5_write_count", writes_seen - w0, 32'd2);
    check("t5_queue_empty", exp_q.size(), 32'd0);
    check("t5_no_int_later", {31'b0, interrupt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
